arb_rr_lock: RTL and testbench
==============================

// Module: arb_rr_lock
//
// PURPOSE
// N-way round-robin arbiter with registered grants and optional per-requester bus locking.
// Generalises the two-requester alternating arbiter to N requesters with fair rotation.
// A holder may lock the grant for a burst; the lock is capped by a hold limit so no requester starves.
// Sits between N bus masters and one shared resource (memory port, bus, FIFO write side).
//
// PARAMETERS
// N        4  number of requesters, >= 2
// MAX_HOLD 8  max consecutive locked cycles before forced rotation when others wait; 0 = unlimited
// IDW      $clog2(N)  localparam, width of grant_id
//
// PORTS
// clk          in   1    single clock, rising edge
// reset_n      in   1    asynchronous, active-low reset
// req          in   N    request vector, bit i = requester i
// lock         in   N    lock qualifier; lock[i] is meaningful only while req[i]=1
// grant        out  N    registered one-hot grant, or all zero
// grant_valid  out  1    registered; equals |grant
// grant_id     out  IDW  registered binary index of granted requester; holds last value when idle
//
// BEHAVIOUR
// - Reset, asserted asynchronously:
//   - grant=0, grant_valid=0, grant_id=0, hold_cnt=0, owner_valid=0.
//   - last pointer = N-1, so requester 0 has top priority after reset.
// - Latency: req sampled at edge k appears as grant after edge k; grant is valid in cycle k+1.
// - State: last (IDW bits) = index of the most recent grant; hold_cnt (counts to MAX_HOLD, saturates);
//   owner_valid = grant_valid.
// - Hold condition, evaluated every cycle:
//   - owner_valid && req[last] && lock[last], and
//   - (MAX_HOLD==0 || hold_cnt < MAX_HOLD-1 || no other req bit set).
// - If hold: grant unchanged; hold_cnt increments, saturating.
// - Else, arbitrate over req:
//   - Search indices last+1, last+2, ... with modulo-N wrap; the first set bit wins.
//   - grant=onehot(winner), grant_id=winner, last=winner.
//   - hold_cnt=0. Also hold_cnt=0 when the same requester is re-granted without lock.
// - No lock asserted: arbitration runs every cycle.
//   - Two active requesters alternate each cycle.
//   - A sole requester is granted every cycle.
// - req==0 (and no hold): grant=0 and grant_valid=0; last and grant_id unchanged.
// - Owner drops req, or lock deasserted: re-arbitrate that same cycle; the result takes effect next cycle.
// - Forced rotation:
//   - After MAX_HOLD consecutive grant cycles to a locked owner with another req pending,
//     the next cycle grants the next requester in RR order.
//   - The former owner gets normal RR priority, i.e. lowest.
// - Pointer wrap: from last=N-1 the search starts at 0. Requests are unmasked, so the owner is searched last.
// - lock[i] while req[i]=0 is ignored.
// - grant is strictly one-hot or zero in every cycle; there are no combinational paths from req to grant.
// - Reset mid-burst: grant drops immediately (async); priority returns to requester 0 after reset release.
//
// TESTING
// 1. Reset/idle: reset_n=0 with req=4'b1111 -> grant=0, grant_id=0.
//    Release, req=0 -> grant stays 0, grant_valid=0.
// 2. Rotation: req=4'b1111 held, lock=0 from reset -> grant_id sequence 0,1,2,3,0,1.
//    grant one-hot every cycle.
// 3. Two-way fairness: req=4'b0101, lock=0 -> grant alternates 4'b0001, 4'b0100.
//    Then req=4'b0100 only -> grant=4'b0100 every cycle.
// 4. Lock cap, MAX_HOLD=8: req=4'b0011, lock=4'b0001 -> requester 0 granted exactly 8 consecutive cycles,
//    then requester 1 granted 1 cycle, then requester 0 again.
//    With req=4'b0001 alone, requester 0 is held indefinitely.
// 5. Drop and wrap: last=3, req=4'b1001, lock=0 -> grant_id=0 next.
//    Owner drops req mid-lock -> next cycle grant moves to the next pending requester in RR order.
// 6. Async reset: assert reset_n=0 mid-cycle during a locked burst -> grant=0 before the next clk edge.
//    After release with req=4'b1110 -> first grant_id=1.

Source files
------------

// File: rtl/arb_rr_lock_if.sv
// Request/grant bundle between N bus masters and the round-robin arbiter.
// Masters drive req/lock; the arbiter returns registered grant information.
interface arb_rr_lock_if #(
  parameter int N = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;

  modport master (
    output req,
    output lock,
    input  grant,
    input  grant_valid,
    input  grant_id
  );

  modport slave (
    input  req,
    input  lock,
    output grant,
    output grant_valid,
    output grant_id
  );
endinterface

// File: rtl/arb_rr_lock.sv
// N-way round-robin arbiter with registered grants and capped bus locking.
// The owner is searched last, so a released lock always yields to waiters.
module arb_rr_lock #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input logic          clk,
  input logic          reset_n,
  arb_rr_lock_if.slave bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HMAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HLIM = CW'(MAX_HOLD - 1);
  localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] last;
  logic [CW-1:0]  hold_cnt;

  logic [N-1:0]   owner_mask;
  logic           others;
  logic           cap_ok;
  logic           hold;
  logic [IDW-1:0] win;
  logic           found;
  int             j;

  assign owner_mask = ONE << last;
  assign others     = |(bus.req & ~owner_mask);

  // Lock may continue while under the cap or while nobody else waits.
  always_comb begin
    cap_ok = 1'b0;
    if (MAX_HOLD == 0) cap_ok = 1'b1;
    else if (hold_cnt < HLIM) cap_ok = 1'b1;
    else if (!others) cap_ok = 1'b1;
    hold = gnt_valid && bus.req[last]
        && bus.lock[last] && cap_ok;
  end

  // Rotating search starting just after the last grant.
  always_comb begin
    win   = last;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last) + k) % N;
      if (!found && bus.req[j]) begin
        win   = IDW'(j);
        found = 1'b1;
      end
    end
  end

  // Grant register: hold, re-arbitrate, or go idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      last      <= IDW'(N - 1);
      hold_cnt  <= '0;
    end else if (hold) begin
      if (hold_cnt != HMAX)
        hold_cnt <= hold_cnt + 1'b1;
    end else if (found) begin
      gnt       <= ONE << win;
      gnt_valid <= 1'b1;
      gnt_id    <= win;
      last      <= win;
      hold_cnt  <= '0;
    end else begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
    end
  end

  assign bus.grant       = gnt;
  assign bus.grant_valid = gnt_valid;
  assign bus.grant_id    = gnt_id;
endmodule

// File: tb/tb_arb_rr_lock.sv
// Directed bench for arb_rr_lock (N=4, MAX_HOLD=8).
// Expected values are hand-derived from the arbitration rules.
module tb_arb_rr_lock;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  arb_rr_lock_if #(.N(4)) bus ();

  arb_rr_lock #(.N(4), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_g(input string tag,
                       input logic [3:0] g,
                       input logic [1:0] id);
    chk({tag, "_grant"}, 32'(bus.grant), 32'(g));
    chk({tag, "_id"}, 32'(bus.grant_id), 32'(id));
    chk({tag, "_valid"}, 32'(bus.grant_valid),
        32'(|g));
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // 1. reset and idle
    reset_n  = 1'b0;
    bus.req  = 4'b1111;
    bus.lock = 4'b0000;
    #2;
    chk_g("rst0", 4'b0000, 2'd0);
    step();
    chk_g("rst1", 4'b0000, 2'd0);
    reset_n = 1'b1;
    bus.req = 4'b0000;
    step();
    chk_g("idle0", 4'b0000, 2'd0);
    step();
    chk_g("idle1", 4'b0000, 2'd0);

    // 2. full rotation, no lock
    bus.req = 4'b1111;
    step(); chk_g("rot0", 4'b0001, 2'd0);
    step(); chk_g("rot1", 4'b0010, 2'd1);
    step(); chk_g("rot2", 4'b0100, 2'd2);
    step(); chk_g("rot3", 4'b1000, 2'd3);
    step(); chk_g("rot4", 4'b0001, 2'd0);
    step(); chk_g("rot5", 4'b0010, 2'd1);

    // 3. two-way fairness then sole requester
    bus.req = 4'b0101;
    step(); chk_g("two0", 4'b0100, 2'd2);
    step(); chk_g("two1", 4'b0001, 2'd0);
    step(); chk_g("two2", 4'b0100, 2'd2);
    step(); chk_g("two3", 4'b0001, 2'd0);
    bus.req = 4'b0100;
    step(); chk_g("sole0", 4'b0100, 2'd2);
    step(); chk_g("sole1", 4'b0100, 2'd2);
    step(); chk_g("sole2", 4'b0100, 2'd2);

    // 4. lock cap: 8 cycles to req 0, one to req 1
    bus.req  = 4'b0011;
    bus.lock = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      step();
      chk_g($sformatf("cap%0d", c), 4'b0001, 2'd0);
    end
    step(); chk_g("cap_rot", 4'b0010, 2'd1);
    step(); chk_g("cap_back", 4'b0001, 2'd0);
    bus.req = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      step();
      chk_g($sformatf("solelock%0d", c), 4'b0001, 2'd0);
    end

    // 5. pointer wrap and owner drop mid-lock
    bus.req  = 4'b1000;
    bus.lock = 4'b0000;
    step(); chk_g("wrap_a", 4'b1000, 2'd3);
    bus.req = 4'b1001;
    step(); chk_g("wrap_b", 4'b0001, 2'd0);
    bus.req  = 4'b0111;
    bus.lock = 4'b1001;
    step(); chk_g("lk0", 4'b0001, 2'd0);
    step(); chk_g("lk1", 4'b0001, 2'd0);
    bus.req = 4'b0110;
    step(); chk_g("drop", 4'b0010, 2'd1);

    // 6. async reset during a locked burst
    bus.req  = 4'b0011;
    bus.lock = 4'b0010;
    step(); chk_g("burst0", 4'b0010, 2'd1);
    step(); chk_g("burst1", 4'b0010, 2'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk_g("async", 4'b0000, 2'd0);
    bus.req  = 4'b1110;
    bus.lock = 4'b0000;
    step();
    chk_g("inrst", 4'b0000, 2'd0);
    reset_n = 1'b1;
    step(); chk_g("post0", 4'b0010, 2'd1);
    step(); chk_g("post1", 4'b0100, 2'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
